// File: rtl/chunked_multicycle_adder.sv
// chunked_multicycle_adder: adds two WIDTH-bit operands CHUNK bits per clock.
// The carry ripples between chunks through a register. Operands enter through
// one valid/ready handshake. The sum, carry-out and signed overflow leave
// through a second valid/ready handshake.
// Optional feature macro: CHUNKED_MULTICYCLE_ADDER_SUB_EN adds a 'sub' input.
// When sub is high, b is inverted at capture, so cin=1 gives a-b.
module chunked_multicycle_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_MULTICYCLE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // The carry into the MSB equals a_msb ^ b_msb ^ s_msb.
    // Overflow is that carry XOR the carry out of the MSB.
    // This form also works when CHUNK is 1.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic c_out);
        return a_msb ^ b_msb ^ s_msb ^ c_out;
    endfunction

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_r;
    logic [IDX_W-1:0] idx_r;

    logic [WIDTH-1:0] b_cap_s;
    logic [CHUNK-1:0] chunk_a_s;
    logic [CHUNK-1:0] chunk_b_s;
    logic [CHUNK:0]   chunk_sum_s;
    logic             last_s;

    // in_ready is held low for as long as reset is asserted.
    assign in_ready = (state_r == S_IDLE) && !rst;

    // Operand B as captured: inverted for subtraction when the feature is built.
    always_comb begin
        b_cap_s = b;
`ifdef CHUNKED_MULTICYCLE_ADDER_SUB_EN
        if (sub) begin
            b_cap_s = ~b;
        end else begin
            b_cap_s = b;
        end
`endif
    end

    // Current chunk addition (unsigned, CHUNK+1 bits including the carry out).
    always_comb begin
        chunk_a_s   = a_q[idx_r*CHUNK +: CHUNK];
        chunk_b_s   = b_q[idx_r*CHUNK +: CHUNK];
        chunk_sum_s = {1'b0, chunk_a_s} + {1'b0, chunk_b_s} + {{CHUNK{1'b0}}, carry_r};
        last_s      = (idx_r == IDX_W'(NCHUNK - 1));
    end

    // Control FSM and datapath registers. All outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            carry_r   <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            sum       <= {WIDTH{1'b0}};
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_cap_s;
                        carry_r <= cin;
                        idx_r   <= {IDX_W{1'b0}};
                        state_r <= S_ADD;
                    end
                end
                S_ADD: begin
                    sum[idx_r*CHUNK +: CHUNK] <= chunk_sum_s[CHUNK-1:0];
                    carry_r <= chunk_sum_s[CHUNK];
                    idx_r   <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        cout      <= chunk_sum_s[CHUNK];
                        ovf       <= ovf_calc(a_q[WIDTH-1], b_q[WIDTH-1],
                                              chunk_sum_s[CHUNK-1], chunk_sum_s[CHUNK]);
                        out_valid <= 1'b1;
                        state_r   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Results stay stable until the consumer takes them.
                    // They are kept after that until the next result is written.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_multicycle_adder.sv
// Self-checking bench for chunked_multicycle_adder.
// It drives an 8/4 instance from a vector table with a scoreboard queue.
// It also runs hand-written corner sequences: backpressure on the 8/4 instance,
// and reset during ADD on a 32/8 instance.
module tb_chunked_multicycle_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    logic clk;
    logic rst;

    // 8-bit / 4-bit chunk instance
    logic       iv8, ir8, ov8, or8, co8, of8, sub8, cin8;
    logic [7:0] a8, b8, s8;

    // 32-bit / 8-bit chunk instance
    logic        rst32, iv32, ir32, ov32, or32, co32, of32, sub32, cin32;
    logic [31:0] a32, b32, s32;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    chunked_multicycle_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin8),
`ifdef CHUNKED_MULTICYCLE_ADDER_SUB_EN
        .sub(sub8),
`endif
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
    );

    chunked_multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst(rst32), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .cin(cin32),
`ifdef CHUNKED_MULTICYCLE_ADDER_SUB_EN
        .sub(sub32),
`endif
        .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .ovf(of32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: full-width add with two's-complement overflow rule.
    function automatic vec_t mk(input logic [7:0] va, input logic [7:0] vb,
                                input logic vcin, input logic vsub);
        vec_t v;
        logic [7:0] beff;
        logic [8:0] full;
        beff  = vsub ? ~vb : vb;
        full  = {1'b0, va} + {1'b0, beff} + {8'd0, vcin};
        v.a   = va; v.b = vb; v.cin = vcin; v.sub = vsub;
        v.s   = full[7:0];
        v.co  = full[8];
        v.ov  = (va[7] == beff[7]) && (full[7] != va[7]);
        return v;
    endfunction

    function automatic vec_t lit(input logic [7:0] va, input logic [7:0] vb, input logic vcin,
                                 input logic vsub, input logic [7:0] vs, input logic vco,
                                 input logic vov);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vcin; v.sub = vsub; v.s = vs; v.co = vco; v.ov = vov;
        return v;
    endfunction

    // Present one operand set and complete the input handshake on dut8.
    task automatic start_op(input vec_t v);
        int n;
        n = 0;
        while (!ir8 && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 32'(ir8), 32'd1);
        a8 = v.a; b8 = v.b; cin8 = v.cin; sub8 = v.sub; iv8 = 1'b1;
        exp_q.push_back(v);
        tick();
        iv8 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0;
        chk("busy_in_ready", 32'(ir8), 32'd0);
    endtask

    // Wait for out_valid, check the latency, and compare against the scoreboard.
    task automatic wait_result();
        int lat;
        vec_t e;
        lat = 0;
        while (!ov8 && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'd2);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("sum", 32'(s8), 32'(e.s));
            chk("cout", 32'(co8), 32'(e.co));
            chk("ovf", 32'(of8), 32'(e.ov));
        end
    endtask

    // Consume the result, then check the return to IDLE and that sum is held.
    task automatic release_op();
        logic [7:0] held;
        held = s8;
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk("out_valid_drop", 32'(ov8), 32'd0);
        chk("in_ready_back", 32'(ir8), 32'd1);
        chk("sum_kept", 32'(s8), 32'(held));
    endtask

    initial begin
        vec_t v;
        logic [7:0] hold_sum;
        int lat;
        int stray;

        rst = 1'b1; rst32 = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0;
        iv32 = 1'b0; or32 = 1'b0; a32 = 32'h0; b32 = 32'h0; cin32 = 1'b0; sub32 = 1'b0;

        // Vector table: test plan cases, then model-derived random cases.
        vecs.push_back(lit(8'h3C, 8'h15, 1'b0, 1'b0, 8'h51, 1'b0, 1'b0));
        vecs.push_back(lit(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0));
        vecs.push_back(lit(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0));
        vecs.push_back(lit(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1));
        vecs.push_back(lit(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1));
        vecs.push_back(lit(8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0));
        vecs.push_back(lit(8'hC0, 8'hC0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0));
`ifdef CHUNKED_MULTICYCLE_ADDER_SUB_EN
        vecs.push_back(lit(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0));
        vecs.push_back(lit(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1));
        vecs.push_back(lit(8'h05, 8'h03, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0));
`endif
        for (int i = 0; i < 6; i++) begin
            vecs.push_back(mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                              1'($urandom_range(0, 1)), 1'b0));
        end

        // Reset state
        tick();
        chk("rst_in_ready", 32'(ir8), 32'd0);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_sum", 32'(s8), 32'd0);
        chk("rst_cout_ovf", {30'd0, co8, of8}, 32'd0);
        rst = 1'b0; rst32 = 1'b0;
        #1;
        chk("idle_in_ready", 32'(ir8), 32'd1);

        // out_ready in IDLE has no effect
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk("idle_out_ready_ov", 32'(ov8), 32'd0);
        chk("idle_out_ready_ir", 32'(ir8), 32'd1);

        // Table-driven pass
        foreach (vecs[i]) begin
            start_op(vecs[i]);
            wait_result();
            release_op();
        end

        // Backpressure: hold the result while new operands wiggle on the inputs
        start_op(lit(8'h3C, 8'h15, 1'b0, 1'b0, 8'h51, 1'b0, 1'b0));
        wait_result();
        hold_sum = 8'h51;
        for (int k = 0; k < 5; k++) begin
            iv8 = ~iv8;
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            cin8 = 1'($urandom_range(0, 1));
            tick();
            chk("bp_out_valid", 32'(ov8), 32'd1);
            chk("bp_sum", 32'(s8), 32'(hold_sum));
            chk("bp_in_ready", 32'(ir8), 32'd0);
        end
        iv8 = 1'b0;
        release_op();
        start_op(lit(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0));
        wait_result();
        release_op();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Reset one edge into ADD on the 32/8 instance
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; iv32 = 1'b1;
        tick();
        iv32 = 1'b0;
        tick();
        rst32 = 1'b1;
        #1;
        chk("r32_sum", s32, 32'd0);
        chk("r32_cout", 32'(co32), 32'd0);
        chk("r32_out_valid", 32'(ov32), 32'd0);
        chk("r32_in_ready", 32'(ir32), 32'd0);
        tick();
        rst32 = 1'b0;
        #1;
        chk("r32_idle", 32'(ir32), 32'd1);
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (ov32) stray++;
        end
        chk("r32_no_stale", 32'(stray), 32'd0);

        // Normal operation on the 32/8 instance afterwards: 4-cycle latency
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; iv32 = 1'b1;
        tick();
        iv32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 20) begin
            tick();
            lat++;
        end
        chk("r32_latency", 32'(lat), 32'd4);
        chk("r32_res_sum", s32, 32'd0);
        chk("r32_res_cout", 32'(co32), 32'd1);
        chk("r32_res_ovf", 32'(of32), 32'd0);
        or32 = 1'b1;
        tick();
        or32 = 1'b0;
        chk("r32_release", 32'(ir32), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chunked_multicycle_adder.md
Name: chunked_multicycle_adder

Overview:
Parametrised multi-cycle adder, the sequential successor of the team's fixed 8-bit ripple adder. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It adds them CHUNK bits per clock, rippling the carry between chunks through a register. It returns sum, carry-out and signed overflow through a second valid/ready handshake. It sits between operand-producing datapath logic and downstream result consumers where a wide single-cycle carry chain would miss timing.

Parameters:
- WIDTH, 8: operand and sum width in bits.
- CHUNK, 4: bits added per clock. WIDTH must be an integer multiple of CHUNK.
- NCHUNK (localparam) = WIDTH/CHUNK: number of add cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operands present on a, b, cin
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in into bit 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered sum
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; sum=0, cout=0, ovf=0, out_valid=0.
  - Chunk index and internal carry cleared; captured operands cleared.
  - in_ready=0 while rst is high.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at an edge: capture a, b; carry_reg=cin; idx=0; go to ADD.
- State ADD:
  - in_ready=0; in_valid is ignored and operands are not sampled.
  - Each edge: {c, s} = a_q[idx*CHUNK +: CHUNK] + b_q[idx*CHUNK +: CHUNK] + carry_reg (CHUNK+1-bit result).
  - Write s into sum[idx*CHUNK +: CHUNK]; carry_reg=c; idx=idx+1.
  - On the edge that processes idx==NCHUNK-1:
    - cout=c.
    - ovf = carry into bit WIDTH-1 XOR c. The carry into the MSB is taken from the sum of the top chunk's bits below its MSB.
    - out_valid=1; go to HOLD.
- State HOLD:
  - out_valid=1; sum, cout and ovf held stable; in_ready=0.
  - On out_ready at an edge: out_valid=0, go to IDLE. in_ready rises the following cycle; no same-cycle accept.
  - sum, cout and ovf keep their last values after the handshake until the next result is written.
- Latency: acceptance edge E. out_valid is high after edge E+NCHUNK. Minimum issue interval is NCHUNK+2 cycles.
- Partial sum bits are visible on sum during ADD but are undefined for consumers until out_valid=1.
- Width rules:
  - All chunk arithmetic is unsigned modulo 2^CHUNK.
  - sum is the full result modulo 2^WIDTH.
  - Operands are interpreted as two's complement for ovf only.
- CHUNK==WIDTH is legal: NCHUNK=1, result one cycle after accept.
- Reset asserted in ADD or HOLD: the operation is aborted, outputs are cleared immediately, and no result is delivered.
- out_ready high outside HOLD has no effect.

Optional Feature:
- Macro CHUNKED_MULTICYCLE_ADDER_SUB_EN.
- When defined:
  - Extra port: sub input 1, sampled with the operands.
  - sub=1 captures b as ~b; carry_reg still starts from cin. a-b therefore requires cin=1, and cin=0 gives a-b-1 (borrow-in).
  - cout=1 means no borrow; ovf is signed subtraction overflow.
  - sub=0 behaves identically to the base block.
- When undefined: no sub port; b is always captured unmodified.

Test Plan:
- WIDTH=8/CHUNK=4: a=0x3C, b=0x15, cin=0 -> sum=0x51, cout=0, ovf=0. out_valid rises exactly 2 cycles after the accept edge.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while toggling in_valid with new operands.
  - out_valid stays 1, sum stays stable, in_ready stays 0, new operands are ignored.
  - After out_ready=1: in_ready=1 on the next cycle and the next operation uses only freshly presented operands.
- Assert rst for 1 cycle one edge into ADD (WIDTH=32/CHUNK=8, a=0xFFFFFFFF, b=1) -> sum=0, cout=0, out_valid=0 immediately. After release: IDLE, in_ready=1, no stale result.
- With CHUNKED_MULTICYCLE_ADDER_SUB_EN, WIDTH=8/CHUNK=4:
  - a=0x10, b=0x20, sub=1, cin=1 -> sum=0xF0, cout=0, ovf=0.
  - a=0x80, b=0x01, sub=1, cin=1 -> sum=0x7F, cout=1, ovf=1.
